pixel_out_stream: RTL
=====================

Name: pixel_out_stream

Overview:
Downstream stage of the image-filter top. Consumes the free-running pixel_out/pixel_valid stream, which has no backpressure. Frames the pixels with start-of-frame and end-of-line markers from the programmed image size. Buffers them in a FIFO and presents them on a valid/ready stream interface for DMA or video output.

Parameters:
DATA_W, 8, pixel width in bits
DIM_W, 12, width of size_x/size_y and internal x/y counters
FIFO_DEPTH, 16, FIFO entries; power of two, at least 4

Ports:
clk  in  1  core clock
rst  in  1  reset; one clock; reset is asynchronous and active-low
start  in  1  frame start pulse, same pulse as given to the filter top
size_x  in  DIM_W  image width in pixels
size_y  in  DIM_W  image height in lines
pixel_in  in  DATA_W  pixel from upstream pixel_out
pixel_valid  in  1  upstream pixel_valid
m_data  out  DATA_W  output pixel at FIFO head
m_valid  out  1  FIFO not empty
m_ready  in  1  downstream accepts the beat
m_sof  out  1  head beat is pixel (0,0) of the frame
m_eol  out  1  head beat is the last pixel of a line
busy  out  1  state is not IDLE
frame_done  out  1  one-cycle pulse when the frame is fully drained
overflow  out  1  sticky: at least one pixel was dropped
level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, FIFO emptied, counters 0. All outputs 0: m_data, m_valid, m_sof, m_eol, busy, frame_done, overflow, level. Reset mid-frame discards everything.
- FSM states: IDLE, ACTIVE, DRAIN.
- IDLE, start=1, both sizes nonzero:
  - latch size_x-1 and size_y-1 (DIM_W arithmetic)
  - clear x/y counters, clear overflow
  - go to ACTIVE
- IDLE, start=1, either size zero: stay IDLE; frame_done pulses the next cycle; overflow cleared.
- start outside IDLE is ignored. pixel_valid in IDLE or DRAIN is ignored: no write, no flag change.
- ACTIVE, pixel_valid=1:
  - form entry {sof=(x==0&&y==0), eol=(x==last_x), pixel_in}
  - write it if accepted
  - x increments; at last_x, x wraps to 0 and y increments
  - the pixel with x==last_x and y==last_y moves the FSM to DRAIN on the same edge
- Counters advance on every ACTIVE pixel_valid, even when the write is dropped, so markers stay aligned with the image geometry.
- Write acceptance: accepted if level<FIFO_DEPTH, or if a pop occurs in the same cycle (level==FIFO_DEPTH && m_valid && m_ready). Otherwise the pixel is dropped and overflow sets. overflow clears only on an accepted start or on reset.
- FIFO is first-word-fall-through:
  - m_data, m_sof and m_eol show the head entry; m_valid = level!=0
  - pop when m_valid && m_ready
  - when empty, m_data/m_sof/m_eol are held at 0
- Latency: a pixel written at edge N appears on m_data with m_valid=1 after edge N, if the FIFO was empty. No bypass path from pixel_in to m_data.
- Simultaneous push and pop: level unchanged. Pointers wrap modulo FIFO_DEPTH; level is pointer difference using an extra MSB.
- DRAIN: when level==0, pulse frame_done for one cycle and go to IDLE. busy=0 from that same cycle.
- m_valid, once high, stays high with a stable head until popped; must never drop without m_ready.

Test Plan:
- 3x2 frame, m_ready=1, pixels 0x10..0x15 → 6 beats in order. m_sof on beat 0 only; m_eol on beats 2 and 5. frame_done one cycle after last pop. overflow=0.
- 4x4 frame, m_ready=0, 16 consecutive pixels → level=16, overflow=0, state DRAIN. Then m_ready=1 → 16 beats in order, eol on beats 3,7,11,15, frame_done after the last beat.
- 5x4 frame (20 pixels), m_ready=0 → first 16 stored, 4 dropped, overflow=1. Drained eol on beats 4,9,14. overflow stays 1 until the next start.
- FIFO full, m_ready=1 and pixel_valid=1 in the same cycle → write accepted, level stays 16, overflow stays 0.
- start pulsed again mid-frame → ignored. pixel_valid pulses in IDLE → level stays 0. start with size_x=0 → frame_done pulse, busy stays 0.
- rst asserted mid-frame with level=7 → m_valid, level, busy, overflow go 0 asynchronously. A following 2x2 frame completes normally with sof on beat 0.

Source files
------------

// File: rtl/pixel_out_stream.sv
// pixel_out_stream
//   Downstream stage of the image-filter top. Frames the free-running
//   pixel stream with start-of-frame / end-of-line markers derived from the
//   programmed image size, buffers {sof, eol, pixel} in a first-word-fall-
//   through FIFO and presents it on a valid/ready stream.
//
// Ports
//   clk, rst            core clock, asynchronous active-low reset
//   start               frame start pulse (accepted only in IDLE)
//   size_x, size_y      image width / height in pixels / lines
//   pixel_in, pixel_valid  upstream pixel stream (no backpressure)
//   m_data, m_valid, m_ready, m_sof, m_eol  output stream, head of FIFO
//   busy                FSM not IDLE
//   frame_done          one-cycle pulse once the frame has fully drained
//   overflow            sticky: a pixel was dropped because the FIFO was full
//   level               FIFO occupancy
module pixel_out_stream #(
    parameter int DATA_W     = 8,
    parameter int DIM_W      = 12,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [DIM_W-1:0]              size_x,
    input  logic [DIM_W-1:0]              size_y,
    input  logic [DATA_W-1:0]             pixel_in,
    input  logic                          pixel_valid,
    output logic [DATA_W-1:0]             m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_sof,
    output logic                          m_eol,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_W + 2;   // {sof, eol, pixel}

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;

    logic [1:0]        r_state;
    logic [DIM_W-1:0]  r_last_x;
    logic [DIM_W-1:0]  r_last_y;
    logic [DIM_W-1:0]  r_x;
    logic [DIM_W-1:0]  r_y;
    logic              r_overflow;
    logic              r_frame_done;
    logic [AW:0]       r_wptr;
    logic [AW:0]       r_rptr;
    logic [EW-1:0]     r_mem [FIFO_DEPTH];

    logic [AW:0]       w_level;
    logic              w_valid;
    logic              w_full;
    logic              w_pop;
    logic              w_pix;
    logic              w_accept;
    logic              w_push;
    logic [EW-1:0]     w_head;
    logic [EW-1:0]     w_entry;

    // Extra pointer MSB distinguishes full from empty.
    assign w_level  = r_wptr - r_rptr;
    assign w_valid  = (w_level != '0);
    assign w_full   = (w_level == (AW+1)'(FIFO_DEPTH));
    assign w_pop    = w_valid && m_ready;
    assign w_pix    = (r_state == S_ACTIVE) && pixel_valid;
    // A full FIFO still takes a write when the head leaves on the same edge.
    assign w_accept = !w_full || w_pop;
    assign w_push   = w_pix && w_accept;
    assign w_entry  = {(r_x == '0) && (r_y == '0), (r_x == r_last_x), pixel_in};
    assign w_head   = r_mem[r_rptr[AW-1:0]];

    assign m_valid    = w_valid;
    assign m_data     = w_valid ? w_head[DATA_W-1:0] : '0;
    assign m_sof      = w_valid & w_head[EW-1];
    assign m_eol      = w_valid & w_head[EW-2];
    assign busy       = (r_state != S_IDLE);
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;
    assign level      = w_level;

    // FIFO storage; stale contents are masked by m_valid so no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= w_entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_last_x     <= '0;
            r_last_y     <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_overflow   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_overflow <= 1'b0;
                        if ((size_x != '0) && (size_y != '0)) begin
                            r_last_x <= size_x - DIM_W'(1);
                            r_last_y <= size_y - DIM_W'(1);
                            r_x      <= '0;
                            r_y      <= '0;
                            r_state  <= S_ACTIVE;
                        end else begin
                            // Empty frame: nothing to stream, report done at once.
                            r_frame_done <= 1'b1;
                        end
                    end
                end
                S_ACTIVE: begin
                    // Counters track geometry even for dropped pixels so
                    // markers on later pixels stay correct.
                    if (pixel_valid) begin
                        if (!w_accept) r_overflow <= 1'b1;
                        if (r_x == r_last_x) begin
                            r_x <= '0;
                            r_y <= r_y + DIM_W'(1);
                            if (r_y == r_last_y) r_state <= S_DRAIN;
                        end else begin
                            r_x <= r_x + DIM_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_level == '0) begin
                        r_frame_done <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
